// File: rtl/spi_master_modes.sv
// spi_master_modes: SPI master with DWIDTH/CLKDIV/NSS parameters and all four CPOL/CPHA modes.
// Optional receive loopback (mosi fed back to the receiver) when SPI_LOOPBACK_EN is defined.
module spi_master_modes #(
    parameter int DWIDTH = 8,
    parameter int CLKDIV = 4,
    parameter int NSS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [DWIDTH-1:0] din,
    input  logic [NSS-1:0]    ss_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DWIDTH-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NSS-1:0]    ss_n
);
    localparam int CW = $clog2(CLKDIV + 1);
    localparam int HW = $clog2(2 * DWIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [HW-1:0]     hc;
    logic [DWIDTH-1:0] tx, rx;
    logic              cpha_q, start, tick, samp, rx_bit;

    assign start = cs & wr & ~rd & (state == IDLE);
    assign tick  = cnt == '0;
    // hc counts down from an odd value, so hc[0]=1 marks a leading-edge boundary
    assign samp  = hc[0] ^ cpha_q;

`ifdef SPI_LOOPBACK_EN
    logic lb_q;
    assign rx_bit = lb_q ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hc     <= '0;
            tx     <= '0;
            rx     <= '0;
            cpha_q <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            ss_n   <= '1;
            dout   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lb_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tx     <= cpha ? din : din << 1;
                        if (!cpha) mosi <= din[DWIDTH-1];
                        cpha_q <= cpha;
                        ss_n   <= ~ss_sel;
                        sclk   <= cpol;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        cnt    <= CW'(CLKDIV - 1);
                        state  <= SETUP;
`ifdef SPI_LOOPBACK_EN
                        lb_q   <= loopback;
`endif
                    end else if (cs & rd & ~wr) begin
                        done <= 1'b0;
                    end
                end
                SETUP: begin
                    cnt <= tick ? CW'(CLKDIV - 1) : cnt - 1'b1;
                    if (tick) begin
                        hc    <= HW'(2 * DWIDTH - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= tick ? CW'(CLKDIV - 1) : cnt - 1'b1;
                    if (tick) begin
                        sclk <= ~sclk;
                        hc   <= hc - 1'b1;
                        // no new bit is driven on the final trailing edge
                        if (samp) begin
                            rx <= {rx[DWIDTH-2:0], rx_bit};
                        end else if (hc != '0) begin
                            mosi <= tx[DWIDTH-1];
                            tx   <= tx << 1;
                        end
                        if (hc == '0) state <= HOLD;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 1'b1;
                    if (tick) begin
                        ss_n  <= '1;
                        dout  <= rx;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
